// File: rtl/uio_bus_arbiter_pkg.sv
// Shared types and defaults for the uio pad-bus arbiter.
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TURN,
    XFER,
    DONE
  } arb_state_t;

  localparam int UIO_W     = 8;
  localparam int N_REQ_DEF = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Bundle of requester handshake and pad-side signals around the arbiter.
// master: user logic / pad side, slave: the arbiter itself.
interface uio_bus_arbiter_if
  import uio_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) ();

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       we;
  logic [N_REQ*UIO_W-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [UIO_W-1:0]       rdata;
  logic [UIO_W-1:0]       uio_in;
  logic [UIO_W-1:0]       uio_out;
  logic [UIO_W-1:0]       uio_oe;

  modport master (
    output req, we, wdata, uio_in,
    input  gnt, done, rdata, uio_out, uio_oe
  );

  modport slave (
    input  req, we, wdata, uio_in,
    output gnt, done, rdata, uio_out, uio_oe
  );

endinterface

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_last,
// wrapping. With UIO_ARB_PRIO0_EN defined, requester 0 overrides the search.
module rr_pick
  import uio_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  int w_pos;

  // Scan from farthest to nearest so the nearest set bit after i_last wins.
  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    w_pos = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_pos = (int'(i_last) + k) % N_REQ;
      if (i_req[w_pos]) o_idx = IW'(w_pos);
    end
`ifdef UIO_ARB_PRIO0_EN
    if (i_req[0]) o_idx = '0;
`endif
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter for the shared 8-bit uio pad bus. Every transfer is
// preceded by TURN_CYCLES with the pads released, then held for HOLD_CYCLES.
// Optional macro UIO_ARB_PRIO0_EN: requester 0 has fixed priority.
//
// state | meaning
// IDLE  | pads released, no grant; arbitrate pending requests
// TURN  | grant shown, pads still released (turnaround)
// XFER  | write: drive captured byte; read: sample uio_in on last cycle
// DONE  | one-cycle done pulse to the winner, update round-robin pointer
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  uio_bus_arbiter_if.slave bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(max2(TURN_CYCLES, HOLD_CYCLES)) + 1;

  arb_state_t       r_state;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_last;
  logic             r_we;
  logic [UIO_W-1:0] r_byte;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic [UIO_W-1:0] r_rdata;
  logic [UIO_W-1:0] r_out;
  logic [UIO_W-1:0] r_oe;

  logic [IW-1:0]    w_idx;
  logic             w_any;
  logic [N_REQ-1:0] w_gnt_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req  (bus.req),
    .i_last (r_last),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_gnt_next = N_REQ'(1) << w_idx;

  // Sequencer: arbitration, turnaround, transfer and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_we    <= 1'b0;
      r_byte  <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_out   <= '0;
      r_oe    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gnt  <= '0;
          r_done <= '0;
          r_oe   <= '0;
          r_out  <= '0;
          if (w_any) begin
            r_idx   <= w_idx;
            r_we    <= bus.we[w_idx];
            r_byte  <= bus.wdata[int'(w_idx)*UIO_W +: UIO_W];
            r_gnt   <= w_gnt_next;
            r_cnt   <= CW'(TURN_CYCLES);
            r_state <= TURN;
          end
        end
        TURN: begin
          if (r_cnt == CW'(1)) begin
            r_cnt   <= CW'(HOLD_CYCLES);
            r_state <= XFER;
            if (r_we) begin
              r_oe  <= '1;
              r_out <= r_byte;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        XFER: begin
          if (r_cnt == CW'(1)) begin
            r_oe    <= '0;
            r_out   <= '0;
            r_done  <= r_gnt;
            r_state <= DONE;
            if (!r_we) r_rdata <= bus.uio_in;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          r_done  <= '0;
          r_gnt   <= '0;
          r_state <= IDLE;
`ifdef UIO_ARB_PRIO0_EN
          if (r_idx != '0) r_last <= r_idx;
`else
          r_last <= r_idx;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.rdata   = r_rdata;
  assign bus.uio_out = r_out;
  assign bus.uio_oe  = r_oe;

endmodule
